// File: rtl/inst_mem_pipe_if.sv
// Fetch/load bus between the PC/fetch stage (master) and the pipelined
// instruction memory (slave).
interface inst_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [1:0]        resp_err;
  logic              flush;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              busy;

  modport master (
    output req_valid, req_addr, flush, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_data, resp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, flush, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_data, resp_err, busy
  );
endinterface

// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory: byte-addressed fetch with LATENCY-cycle
// in-order responses, program-load write port, flush and address checks.
module inst_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2     // 1..4
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_mem_pipe_if.slave   bus
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [1:0]        err;   // bit0 misaligned, bit1 out of range
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] mem [DEPTH];
  stage_t            pipe [LATENCY];

  logic             req_ready;
  logic             accept;
  logic [IDX_W-1:0] fetch_idx;
  logic [1:0]       fetch_err;
  logic [IDX_W-1:0] load_idx;
  logic             load_ok;
  logic             busy;

  // Load has priority over fetch; flush also blocks the fetch port.
  assign req_ready = rst_n && !bus.load_en && !bus.flush;

  always_comb begin
    fetch_idx    = bus.req_addr[ADDR_W-1:2];
    fetch_err[0] = |bus.req_addr[1:0];
    fetch_err[1] = (fetch_idx >= DEPTH_IDX);
    accept       = bus.req_valid && req_ready;
    load_idx     = bus.load_addr[ADDR_W-1:2];
    load_ok      = bus.load_en && (bus.load_addr[1:0] == 2'b00) && (load_idx < DEPTH_IDX);
  end

  // NOTE: the storage array deliberately has no reset so it maps onto RAM and
  // keeps the loaded program across a pipeline reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx[MEM_AW-1:0]] <= bus.load_data;
    end
  end

  // Stage 0 performs the array read; a same-edge write is not yet visible,
  // which gives read-before-write ordering. Idle or faulted entries carry zero
  // data so the response outputs need no extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].valid <= accept;
      pipe[0].err   <= accept ? fetch_err : 2'b00;
      pipe[0].data  <= (accept && fetch_err == 2'b00) ? mem[fetch_idx[MEM_AW-1:0]] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= bus.flush ? '0 : pipe[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | pipe[i].valid;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = pipe[LATENCY-1].valid;
  assign bus.resp_data  = pipe[LATENCY-1].data;
  assign bus.resp_err   = pipe[LATENCY-1].err;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed bench: three instances (LATENCY 1/2/4) share one stimulus stream;
// expected values come from hand-written vectors and a tiny latency model.
module tb_inst_mem_pipe;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] bd [3];
  logic [1:0]  be [3];

  inst_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  inst_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) if2 ();
  inst_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) if4 ();

  assign if1.req_valid = req_valid;  assign if1.req_addr  = req_addr;
  assign if1.flush     = flush;      assign if1.load_en   = load_en;
  assign if1.load_addr = load_addr;  assign if1.load_data = load_data;
  assign if2.req_valid = req_valid;  assign if2.req_addr  = req_addr;
  assign if2.flush     = flush;      assign if2.load_en   = load_en;
  assign if2.load_addr = load_addr;  assign if2.load_data = load_data;
  assign if4.req_valid = req_valid;  assign if4.req_addr  = req_addr;
  assign if4.flush     = flush;      assign if4.load_en   = load_en;
  assign if4.load_addr = load_addr;  assign if4.load_data = load_data;

  inst_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(1000), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  inst_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));
  inst_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(1000), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of a LATENCY=lat instance after burst step s
  // (request j is accepted at step j and is in flight for steps j..j+lat-1).
  task automatic chk_burst(input string nm, input int lat, input int s,
                           input logic v, input logic [31:0] d,
                           input logic [1:0] e, input logic b);
    int          r;
    logic        ev;
    logic        eb;
    logic [31:0] ed;
    logic [1:0]  ee;
    r  = s - (lat - 1);
    ev = (r >= 0 && r < 3);
    ed = 32'h0;
    ee = 2'b00;
    if (ev) begin
      ed = bd[r];
      ee = be[r];
    end
    eb = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j <= s && s <= j + lat - 1) eb = 1'b1;
    end
    chk($sformatf("%s s%0d resp_valid", nm, s), {31'b0, v}, {31'b0, ev});
    chk($sformatf("%s s%0d resp_data", nm, s), d, ed);
    chk($sformatf("%s s%0d resp_err", nm, s), {30'b0, e}, {30'b0, ee});
    chk($sformatf("%s s%0d busy", nm, s), {31'b0, b}, {31'b0, eb});
  endtask

  task automatic burst3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2,
                        input bit chk2);
    logic [31:0] a [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    bd[0] = d0; bd[1] = d1; bd[2] = d2;
    be[0] = e0; be[1] = e1; be[2] = e2;
    for (int s = 0; s < 7; s++) begin
      if (s < 3) begin
        req_valid = 1'b1;
        req_addr  = a[s];
      end else begin
        req_valid = 1'b0;
        req_addr  = 32'h0;
      end
      step();
      chk_burst("L1", 1, s, if1.resp_valid, if1.resp_data, if1.resp_err, if1.busy);
      if (chk2) chk_burst("L2", 2, s, if2.resp_valid, if2.resp_data, if2.resp_err, if2.busy);
      chk_burst("L4", 4, s, if4.resp_valid, if4.resp_data, if4.resp_err, if4.busy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;

    // Reset state
    #12;
    chk("rst resp_valid", {31'b0, if2.resp_valid}, 32'h0);
    chk("rst resp_data",  if2.resp_data, 32'h0);
    chk("rst resp_err",   {30'b0, if2.resp_err}, 32'h0);
    chk("rst busy",       {31'b0, if2.busy}, 32'h0);
    chk("rst req_ready",  {31'b0, if2.req_ready}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle req_ready", {31'b0, if2.req_ready}, 32'h1);

    // Program load: words 0..5, word 999, then a misaligned load that must be dropped
    for (int k = 0; k < 6; k++) begin
      load_en   = 1'b1;
      load_addr = 32'(4 * k);
      load_data = 32'h7002_0004 + 32'(k);
      #1;
      chk($sformatf("load%0d req_ready", k), {31'b0, if2.req_ready}, 32'h0);
      step();
    end
    load_addr = 32'd3996; load_data = 32'h1234_5678; step();
    load_addr = 32'd13;   load_data = 32'hBAD0_BAD0; step();
    load_en   = 1'b0;

    // Back-to-back fetches, all three latencies
    burst3(32'd0, 32'd4, 32'd8, 32'h7002_0004, 32'h7002_0005, 32'h7002_0006,
           2'b00, 2'b00, 2'b00, 1'b1);

    // Address faults
    burst3(32'd6, 32'd4096, 32'd4097, 32'h0, 32'h0, 32'h0,
           2'b01, 2'b10, 2'b11, 1'b1);

    // Load/fetch hazard on word 2
    req_valid = 1'b1; req_addr = 32'd8;
    step();
    load_en = 1'b1; load_addr = 32'd8; load_data = 32'hDEAD_BEEF;
    #1;
    chk("hz req_ready blocked", {31'b0, if2.req_ready}, 32'h0);
    step();
    chk("hz old valid", {31'b0, if2.resp_valid}, 32'h1);
    chk("hz old data",  if2.resp_data, 32'h7002_0006);
    load_en = 1'b0;
    #1;
    chk("hz req_ready again", {31'b0, if2.req_ready}, 32'h1);
    step();
    chk("hz gap valid", {31'b0, if2.resp_valid}, 32'h0);
    req_valid = 1'b0;
    step();
    chk("hz new valid", {31'b0, if2.resp_valid}, 32'h1);
    chk("hz new data",  if2.resp_data, 32'hDEAD_BEEF);
    step();
    chk("hz end valid", {31'b0, if2.resp_valid}, 32'h0);
    chk("hz end busy",  {31'b0, if2.busy}, 32'h0);
    step();
    step();

    // Flush with two requests in flight, plus a load in the flush cycle
    req_valid = 1'b1; req_addr = 32'd0;
    step();
    chk("fl L1 resp0",     if1.resp_data, 32'h7002_0004);
    chk("fl L2 busy",      {31'b0, if2.busy}, 32'h1);
    req_addr = 32'd4;
    step();
    chk("fl L2 presented", {31'b0, if2.resp_valid}, 32'h1);
    chk("fl L2 data",      if2.resp_data, 32'h7002_0004);
    chk("fl L4 busy",      {31'b0, if4.busy}, 32'h1);
    req_addr = 32'd12; flush = 1'b1;
    load_en = 1'b1; load_addr = 32'd16; load_data = 32'hCAFE_F00D;
    #1;
    chk("fl req_ready", {31'b0, if2.req_ready}, 32'h0);
    step();
    flush = 1'b0; load_en = 1'b0; req_valid = 1'b0;
    chk("fl L2 valid",  {31'b0, if2.resp_valid}, 32'h0);
    chk("fl L2 busy0",  {31'b0, if2.busy}, 32'h0);
    chk("fl L4 busy0",  {31'b0, if4.busy}, 32'h0);
    chk("fl L1 valid",  {31'b0, if1.resp_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("fl L4 quiet%0d", k), {31'b0, if4.resp_valid}, 32'h0);
      chk($sformatf("fl L2 quiet%0d", k), {31'b0, if2.resp_valid}, 32'h0);
    end
    // Word 3 keeps its value (misaligned load dropped); word 4 took the flush-cycle load
    burst3(32'd12, 32'd16, 32'd20, 32'h7002_0007, 32'hCAFE_F00D, 32'h7002_0009,
           2'b00, 2'b00, 2'b00, 1'b1);

    // Asynchronous reset mid-cycle with requests in flight
    req_valid = 1'b1; req_addr = 32'd0;
    step();
    req_addr = 32'd4;
    step();
    req_valid = 1'b0;
    chk("rs pre valid", {31'b0, if2.resp_valid}, 32'h1);
    chk("rs pre busy4", {31'b0, if4.busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs valid",     {31'b0, if2.resp_valid}, 32'h0);
    chk("rs data",      if2.resp_data, 32'h0);
    chk("rs busy",      {31'b0, if2.busy}, 32'h0);
    chk("rs busy4",     {31'b0, if4.busy}, 32'h0);
    chk("rs req_ready", {31'b0, if2.req_ready}, 32'h0);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rs L2 quiet%0d", k), {31'b0, if2.resp_valid}, 32'h0);
      chk($sformatf("rs L4 quiet%0d", k), {31'b0, if4.resp_valid}, 32'h0);
    end
    burst3(32'd0, 32'd4, 32'd20, 32'h7002_0004, 32'h7002_0005, 32'h7002_0009,
           2'b00, 2'b00, 2'b00, 1'b1);

    // DEPTH=1000 boundary on the LATENCY 1 and 4 instances
    burst3(32'd3996, 32'd4000, 32'd0, 32'h1234_5678, 32'h0, 32'h7002_0004,
           2'b00, 2'b10, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
- Parametrised, pipelined instruction memory for the MIPS datapaths; successor to the combinational single-cycle instruction ROM.
- Byte-addressed fetch port, word-indexed storage, configurable read latency, valid/ready request handshake, and a program-load write port.
- Adds flush, misalignment detection and out-of-range detection; sits between the PC/fetch stage and the decode stage.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 32, fetch/load byte-address width.
- DEPTH, 1024, number of instruction words; need not be a power of two.
- LATENCY, 2, read latency in cycles from request accept to response; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  fetch request accepted this cycle when high together with req_valid.
- req_addr  input  ADDR_W  fetch byte address.
- resp_valid  output  1  response word valid this cycle.
- resp_data  output  DATA_W  fetched instruction.
- resp_err  output  2  bit0 = misaligned, bit1 = out of range.
- flush  input  1  discard all in-flight requests (branch/jump redirect).
- load_en  input  1  program-load write strobe.
- load_addr  input  ADDR_W  load byte address.
- load_data  input  DATA_W  load word.
- busy  output  1  at least one request in flight.

Behaviour:
- Reset (rst_n low, async): all pipeline valid bits clear. Reset values: resp_valid=0, resp_data=0, resp_err=0, busy=0, req_ready=0 while asserted. Memory array is not reset; contents are undefined until loaded.
- Word index = addr[ADDR_W-1:2].
- req_ready = !load_en && !flush; no other stall source.
- Accept rule: a request is accepted when req_valid && req_ready. Up to LATENCY requests are in flight; one new request can be accepted per cycle, fully pipelined.
- Response timing: a request accepted at edge N produces resp_valid=1 for exactly one cycle after edge N+LATENCY-1. LATENCY=1 means the response is visible in the cycle after accept.
- Response ordering: responses return in acceptance order. The response path has no backpressure.
- Error checks (evaluated at accept):
  - misaligned if addr[1:0] != 0;
  - out of range if word index >= DEPTH.
  - On any error, resp_data=0 and the corresponding resp_err bits are set. Both bits may be set together.
  - When resp_valid=0, resp_data and resp_err are held at 0.
- Memory read: the array read occurs in the first pipeline stage; later stages only register data.
- Load writes:
  - Occur at the clock edge when load_en=1 and the load word index < DEPTH.
  - Misaligned or out-of-range loads are silently dropped.
  - load_addr[1:0] is ignored only when it is 0; otherwise the load is dropped.
- Load/fetch same-address hazard: a fetch accepted before a load edge to the same word returns the old data (read-before-write). A fetch accepted after the load edge returns the new data.
- Flush:
  - At the edge where flush=1, all in-flight valid bits clear; no response is produced for those requests.
  - No request is accepted in the flush cycle.
  - resp_valid=0 in the cycle after the flush edge.
  - A flush that coincides with a response already presented that cycle does not retract it.
- Simultaneous events:
  - load_en && req_valid: load wins and the request is not accepted (requester holds).
  - flush && load_en: both take effect.
- busy = OR of all pipeline valid bits.
- Reset mid-operation: in-flight requests are lost and no responses are emitted after reset. Memory contents are retained.

Test Plan:
- Load words 0..5 with 0x7002_0004..0x7002_0009 at addresses 0,4,...,20. Then issue back-to-back fetches to 0,4,8 with LATENCY=2 -> resp_valid on 3 consecutive cycles starting 2 cycles after the first accept; data matches in order; resp_err=0.
- Fetch addr 0x6 -> resp_err=2'b01, resp_data=0. Fetch addr 4*DEPTH (4096) -> resp_err=2'b10. Fetch 4*DEPTH+1 -> resp_err=2'b11.
- Load 0xDEAD_BEEF to addr 8 in the same cycle as req_valid to addr 8 -> req_ready=0. Next cycle the fetch is accepted and returns 0xDEAD_BEEF. A fetch to addr 8 accepted one cycle earlier returns the old word.
- Issue 2 fetches, then assert flush for one cycle before either response -> no resp_valid for them, busy=0 after the flush edge. A fetch after the flush returns the correct data with normal latency.
- Drop rst_n asynchronously mid-clock with 2 requests in flight -> resp_valid/busy go 0 immediately and no stale responses appear after release. A re-fetch of a previously loaded address returns the retained data.
- Repeat the first scenario with LATENCY=1 and LATENCY=4 and DEPTH=1000 -> latency tracks the parameter; addr 3996 is valid, addr 4000 flags out of range.
